// File: rtl/rb_alu_sequencer_if.sv
// Bus bundle for the reg_bank/alu issue sequencer: micro-op input handshake,
// reg_bank/alu control outputs, alu status inputs and retirement reporting.
interface rb_alu_sequencer_if #(
  parameter int CNT_W = 16
) ();
  // Handshake: a micro-op transfers on a rising edge where in_valid && in_ready.
  // in_ready is combinational from pipeline state only (never from in_valid);
  // the producer must hold in_instr stable while in_valid && !in_ready.
  logic             in_valid;
  logic             in_ready;
  logic [19:0]      in_instr;
  logic [4:0]       raddr1;
  logic [4:0]       raddr2;
  logic [4:0]       op;
  logic [4:0]       waddr;
  logic             w_enable;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_zero;
  logic [2:0]       status;
  logic             status_valid;
  logic [CNT_W-1:0] retire_count;
  logic             busy;

  modport master (
    output in_valid, in_instr, alu_carry, alu_overflow, alu_zero,
    input  in_ready, raddr1, raddr2, op, waddr, w_enable,
           status, status_valid, retire_count, busy
  );

  modport slave (
    input  in_valid, in_instr, alu_carry, alu_overflow, alu_zero,
    output in_ready, raddr1, raddr2, op, waddr, w_enable,
           status, status_valid, retire_count, busy
  );
endinterface

// File: rtl/rb_alu_sequencer.sv
// Three-stage F/E/W issue pipeline for the reg_bank + alu datapath with
// read-after-write stall (no forwarding), status capture and retire counting.
module rb_alu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  rb_alu_sequencer_if.slave   bus
);
  typedef struct packed {
    logic        valid;
    logic [19:0] instr;
  } stage_t;

  stage_t           f_q, f_d;
  stage_t           e_q, e_d;
  stage_t           w_q, w_d;
  logic [2:0]       status_q, status_d;
  logic             status_valid_q, status_valid_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;
  logic             stall;
  logic             accept;

  // rs==0 reads x0, which is never written, so it cannot collide with a producer.
  function automatic logic src_hazard(input logic [4:0] rs, input stage_t e, input stage_t w);
    return (rs != 5'd0) &&
           ((e.valid && (e.instr[9:5] == rs)) || (w.valid && (w.instr[9:5] == rs)));
  endfunction

  always_comb begin
    stall  = f_q.valid &&
             (src_hazard(f_q.instr[19:15], e_q, w_q) || src_hazard(f_q.instr[14:10], e_q, w_q));
    accept = bus.in_valid && !stall;

    w_d = e_q;
    f_d = f_q;
    e_d = '0;
    if (!stall) begin
      e_d = f_q;
      f_d = accept ? stage_t'{valid: 1'b1, instr: bus.in_instr}
                   : stage_t'{valid: 1'b0, instr: f_q.instr};
    end

    status_d       = status_q;
    status_valid_d = 1'b0;
    retire_count_d = retire_count_q;
    if (w_q.valid) begin
      status_d       = {bus.alu_carry, bus.alu_overflow, bus.alu_zero};
      status_valid_d = 1'b1;
      retire_count_d = retire_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      f_q            <= '0;
      e_q            <= '0;
      w_q            <= '0;
      status_q       <= '0;
      status_valid_q <= 1'b0;
      retire_count_q <= '0;
    end else begin
      f_q            <= f_d;
      e_q            <= e_d;
      w_q            <= w_d;
      status_q       <= status_d;
      status_valid_q <= status_valid_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign bus.in_ready     = !stall;
  assign bus.raddr1       = f_q.instr[19:15];
  assign bus.raddr2       = f_q.instr[14:10];
  assign bus.op           = e_q.valid ? e_q.instr[4:0] : 5'd0;
  assign bus.waddr        = w_q.instr[9:5];
  // Ops targeting x0 still retire but never strobe the register file.
  assign bus.w_enable     = w_q.valid && (w_q.instr[9:5] != 5'd0);
  assign bus.status       = status_q;
  assign bus.status_valid = status_valid_q;
  assign bus.retire_count = retire_count_q;
  assign bus.busy         = f_q.valid | e_q.valid | w_q.valid;
endmodule

// File: tb/tb_rb_alu_sequencer.sv
// Self-checking bench for rb_alu_sequencer: a per-op schedule model (accept,
// execute and write cycles derived from the hazard rules) predicts every output.
module tb_rb_alu_sequencer;
  localparam int CNT_W = 4;
  localparam int N     = 4096;
  localparam logic [4:0] ADD = 5'd1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rb_alu_sequencer_if #(.CNT_W(CNT_W)) bus ();
  rb_alu_sequencer #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  bit force_flags = 1'b0;

  // Expected per-cycle view of the outputs, filled as ops are accepted.
  bit         exp_ready [N];
  bit         exp_busy  [N];
  bit         exp_wen   [N];
  bit         exp_ret   [N];
  logic [4:0] exp_op    [N];
  logic [4:0] exp_waddr [N];
  logic [4:0] exp_r1    [N];
  logic [4:0] exp_r2    [N];
  logic [2:0] flag_hist [N];

  int         last_e;
  int         prod_e[$];
  logic [4:0] prod_rd[$];
  logic [2:0] m_status;
  logic [CNT_W-1:0] m_count;
  bit         m_sv;
  int         sv_pulses;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (force_flags) {bus.alu_carry, bus.alu_overflow, bus.alu_zero} = 3'b101;
    else             {bus.alu_carry, bus.alu_overflow, bus.alu_zero} = 3'($urandom);
  end

  function automatic logic [19:0] mk(input int rs1, input int rs2, input int rd, input logic [4:0] opc);
    return {5'(rs1), 5'(rs2), 5'(rd), opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_model();
    int lo;
    lo = (cyc > 2) ? cyc - 2 : 0;
    for (int c = lo; c < N; c++) begin
      exp_ready[c] = 1'b1; exp_busy[c] = 1'b0; exp_wen[c] = 1'b0; exp_ret[c] = 1'b0;
      exp_op[c] = '0; exp_waddr[c] = '0; exp_r1[c] = '0; exp_r2[c] = '0;
    end
    prod_e.delete();
    prod_rd.delete();
    last_e   = -100;
    m_status = '0;
    m_count  = '0;
  endtask

  // Monitor: every checked cycle compares all outputs against the schedule.
  always @(negedge clk) begin
    flag_hist[cyc] = {bus.alu_carry, bus.alu_overflow, bus.alu_zero};
    if (bus.status_valid === 1'b1) sv_pulses++;
    if (chk_en) begin
      m_sv = exp_ret[cyc-1];
      if (m_sv) begin
        m_status = flag_hist[cyc-1];
        m_count  = m_count + 1'b1;
      end
      n_checks++;
      if (bus.in_ready !== exp_ready[cyc]) begin
        n_fail++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_ready[cyc]);
      end
      n_checks++;
      if (bus.raddr1 !== exp_r1[cyc] || bus.raddr2 !== exp_r2[cyc]) begin
        n_fail++; $display("FAIL raddr cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, bus.raddr1, bus.raddr2, exp_r1[cyc], exp_r2[cyc]);
      end
      n_checks++;
      if (bus.op !== exp_op[cyc]) begin
        n_fail++; $display("FAIL op cyc=%0d got=%0d exp=%0d", cyc, bus.op, exp_op[cyc]);
      end
      n_checks++;
      if (bus.w_enable !== exp_wen[cyc]) begin
        n_fail++; $display("FAIL w_enable cyc=%0d got=%b exp=%b", cyc, bus.w_enable, exp_wen[cyc]);
      end
      if (exp_wen[cyc]) begin
        n_checks++;
        if (bus.waddr !== exp_waddr[cyc]) begin
          n_fail++; $display("FAIL waddr cyc=%0d got=%0d exp=%0d", cyc, bus.waddr, exp_waddr[cyc]);
        end
      end
      n_checks++;
      if (bus.busy !== exp_busy[cyc]) begin
        n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy[cyc]);
      end
      n_checks++;
      if (bus.status_valid !== m_sv || bus.status !== m_status) begin
        n_fail++; $display("FAIL status cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.status_valid, bus.status, m_sv, m_status);
      end
      n_checks++;
      if (bus.retire_count !== m_count) begin
        n_fail++; $display("FAIL retire_count cyc=%0d got=%0d exp=%0d", cyc, bus.retire_count, m_count);
      end
    end
  end

  // Presents one op after gap idle cycles, holds it until the handshake fires,
  // and records when it should issue and retire.
  task automatic send_op(input logic [19:0] instr, input int gap);
    int p, a_pred, a_act, e, w;
    bit got;
    logic [4:0] rs1, rs2, rd;
    rs1 = instr[19:15]; rs2 = instr[14:10]; rd = instr[9:5];
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    p      = cyc;
    a_pred = (p > last_e - 1) ? p : last_e - 1;
    got    = 1'b0;
    a_act  = -1;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        got = 1'b1; a_act = cyc;
      end else begin
        tick();
      end
    end
    n_checks++;
    if (a_act != a_pred) begin
      n_fail++; $display("FAIL accept_cycle instr=%h got=%0d exp=%0d", instr, a_act, a_pred);
    end
    e = a_pred + 2;
    for (int j = 0; j < prod_e.size(); j++)
      if (prod_rd[j] != 5'd0 && (prod_rd[j] == rs1 || prod_rd[j] == rs2) && prod_e[j] + 3 > e)
        e = prod_e[j] + 3;
    w = e + 1;
    for (int c = a_pred + 1; c <= e - 2; c++) exp_ready[c] = 1'b0;
    for (int c = a_pred + 1; c <= w; c++)     exp_busy[c]  = 1'b1;
    for (int c = a_pred + 1; c < N; c++) begin
      exp_r1[c] = rs1; exp_r2[c] = rs2;
    end
    exp_op[e]    = instr[4:0];
    exp_wen[w]   = (rd != 5'd0);
    exp_waddr[w] = rd;
    exp_ret[w]   = 1'b1;
    last_e = e;
    prod_e.push_back(e);
    prod_rd.push_back(rd);
    tick();
    bus.in_valid = 1'b0;
    bus.in_instr = 20'($urandom);
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.w_enable !== 1'b0 || bus.retire_count !== '0 || bus.status !== 3'b000) begin
      n_fail++; $display("FAIL por_state busy=%b wen=%b cnt=%0d st=%b exp=0", bus.busy, bus.w_enable, bus.retire_count, bus.status);
    end
    tick();
    reset = 1'b1;
    init_model();
    chk_en = 1'b1;
    send_op(mk(11, 12, 13, ADD), 0);
    send_op(mk(14, 15, 16, ADD), 0);
    send_op(mk(17, 18, 19, ADD), 0);
    chk_en = 1'b0;
    reset  = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.raddr1, bus.raddr2, bus.op, bus.waddr} !== 20'd0 || bus.w_enable !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs r=%0d/%0d op=%0d wa=%0d wen=%b busy=%b exp=0", bus.raddr1, bus.raddr2, bus.op, bus.waddr, bus.w_enable, bus.busy);
    end
    n_checks++;
    if (bus.retire_count !== '0 || bus.status !== 3'b000 || bus.status_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_status cnt=%0d st=%b sv=%b exp=0", bus.retire_count, bus.status, bus.status_valid);
    end
    tick();
    reset = 1'b1;
    init_model();
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.w_enable !== 1'b0 || bus.retire_count !== '0) begin
        n_fail++; $display("FAIL post_reset k=%0d wen=%b cnt=%0d exp=0/0", k, bus.w_enable, bus.retire_count);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] base;
    base = m_count;
    send_op(mk(2, 3, 4, ADD), 0);
    send_op(mk(5, 6, 7, ADD), 0);
    send_op(mk(8, 9, 10, ADD), 0);
    drain();
    n_checks++;
    if (bus.retire_count !== CNT_W'(base + 3)) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", bus.retire_count, CNT_W'(base + 3));
    end
  endtask

  task automatic test_hazard();
    send_op(mk(2, 3, 4, ADD), 0);
    send_op(mk(4, 5, 6, ADD), 0);
    drain();
  endtask

  task automatic test_x0();
    logic [CNT_W-1:0] base;
    base = m_count;
    send_op(mk(1, 1, 0, ADD), 0);
    send_op(mk(0, 0, 5, ADD), 0);
    drain();
    n_checks++;
    if (bus.retire_count !== CNT_W'(base + 2)) begin
      n_fail++; $display("FAIL x0_count got=%0d exp=%0d", bus.retire_count, CNT_W'(base + 2));
    end
  endtask

  task automatic test_status();
    force_flags = 1'b1;
    sv_pulses   = 0;
    send_op(mk(3, 3, 9, 5'd7), 0);
    drain();
    n_checks++;
    if (bus.status !== 3'b101) begin
      n_fail++; $display("FAIL status_flags got=%b exp=101", bus.status);
    end
    n_checks++;
    if (sv_pulses != 1) begin
      n_fail++; $display("FAIL status_pulses got=%0d exp=1", sv_pulses);
    end
    force_flags = 1'b0;
  endtask

  task automatic test_wrap();
    chk_en = 1'b0;
    reset  = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    init_model();
    chk_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 8) send_op(mk(20, 21, 22, ADD), 0);
      else if (i == 9) send_op(mk(22, 22, 23, ADD), 0);
      else send_op(mk(0, 0, $urandom_range(1, 31), 5'($urandom)), 0);
    end
    drain();
    n_checks++;
    if (bus.retire_count !== CNT_W'(1)) begin
      n_fail++; $display("FAIL wrap_count got=%0d exp=1", bus.retire_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      send_op(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 5'($urandom)),
              $urandom_range(0, 2));
    drain();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    test_reset();
    test_back_to_back();
    test_hazard();
    test_x0();
    test_status();
    test_wrap();
    test_random();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
